// File: rtl/exu_issue_ctrl_pkg.sv
// Shared execute-stage definitions for the multi-cycle unit issue controller.
package exu_issue_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam int unsigned UNIT_CLZ  = 0;
  localparam int unsigned UNIT_MUL  = 1;
  localparam int unsigned UNIT_DIV  = 2;
  localparam int unsigned UNIT_DIVU = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } issue_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } unit_result_t;

endpackage

// File: rtl/unit_result_mux.sv
// Selects one unit's lo/hi result slice from the flattened per-unit result buses.
module unit_result_mux
  import exu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned SEL_W     = 2
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [XLEN*NUM_UNITS-1:0] unit_lo,
  input  logic [XLEN*NUM_UNITS-1:0] unit_hi,
  output unit_result_t              result_c
);

  // Indices with no attached unit read as zero.
  always_comb begin
    result_c = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (sel == SEL_W'(i)) begin
        result_c.lo = unit_lo[XLEN*i +: XLEN];
        result_c.hi = unit_hi[XLEN*i +: XLEN];
      end
    end
  end

endmodule

// File: rtl/exu_issue_ctrl.sv
// Execute-stage start/busy initiator: launches a multi-cycle unit, stalls the
// pipeline until it finishes, and handles flush, drain and hung units.
module exu_issue_ctrl
  import exu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue,
  input  logic                      flush,
  input  logic [SEL_W-1:0]          unit_sel,
  input  logic [XLEN-1:0]           rs_value,
  input  logic [XLEN-1:0]           rt_value,
  output logic [XLEN-1:0]           op_a,
  output logic [XLEN-1:0]           op_b,
  output logic [NUM_UNITS-1:0]      start,
  input  logic [NUM_UNITS-1:0]      busy,
  input  logic [XLEN*NUM_UNITS-1:0] unit_lo,
  input  logic [XLEN*NUM_UNITS-1:0] unit_hi,
  output logic                      stall,
  output logic [XLEN-1:0]           result_lo,
  output logic [XLEN-1:0]           result_hi,
  output logic                      result_valid,
  output logic                      timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  issue_state_e     state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0]  op_a_d, op_b_d, result_lo_d, result_hi_d;
  logic             timeout_err_d;
  logic             busy_sel;
  logic             sel_ok;
  unit_result_t     mux_result;

  unit_result_mux #(
    .NUM_UNITS (NUM_UNITS),
    .SEL_W     (SEL_W)
  ) u_result_mux (
    .sel      (sel_q),
    .unit_lo  (unit_lo),
    .unit_hi  (unit_hi),
    .result_c (mux_result)
  );

  assign sel_ok = (32'(unit_sel) < NUM_UNITS);

  // Busy of the latched unit; an unattached index never reports busy.
  always_comb begin
    busy_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (sel_q == SEL_W'(i)) busy_sel = busy[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      wait_cnt_q  <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wait_cnt_q  <= wait_cnt_d;
      op_a        <= op_a_d;
      op_b        <= op_b_d;
      result_lo   <= result_lo_d;
      result_hi   <= result_hi_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next state plus operand/result/counter updates.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    wait_cnt_d    = wait_cnt_q;
    op_a_d        = op_a;
    op_b_d        = op_b;
    result_lo_d   = result_lo;
    result_hi_d   = result_hi;
    timeout_err_d = timeout_err;
    case (state_q)
      ST_IDLE: begin
        if (issue && !flush) begin
          op_a_d = rs_value;
          op_b_d = rt_value;
          sel_d  = unit_sel;
          if (sel_ok) begin
            state_d = ST_START;
          end else begin
            timeout_err_d = 1'b1;
            result_lo_d   = '0;
            result_hi_d   = '0;
            state_d       = ST_DONE;
          end
        end
      end
      ST_START: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = busy_sel ? ST_DRAIN : ST_IDLE;
        end else if (!busy_sel) begin
          result_lo_d = mux_result.lo;
          result_hi_d = mux_result.hi;
          state_d     = ST_DONE;
        end else if (wait_cnt_q == CNT_MAX) begin
          result_lo_d   = '0;
          result_hi_d   = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      // Flushed work still in flight: wait it out, discarding its result.
      ST_DRAIN: begin
        if (!busy_sel) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == CNT_MAX) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; all forced low during reset.
  always_comb begin
    start        = '0;
    stall        = 1'b0;
    result_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE:  stall = issue & ~flush;
        ST_START: begin
          stall = ~flush;
          for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            start[i] = (sel_q == SEL_W'(i)) & ~flush;
          end
        end
        ST_WAIT:  stall = ~flush;
        ST_DONE:  result_valid = 1'b1;
        ST_DRAIN: stall = issue & ~flush;
        default:  stall = 1'b0;
      endcase
    end
  end

endmodule
